multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit_pkg.sv | 72 +++++++
 rtl/multicycle_control_unit_alu_decoder.sv | 37 +++
 rtl/multicycle_control_unit.sv | 172 +++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, ALUOp,
// ALUControl codes, opcodes and datapath mux selects.
package multicycle_control_unit_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH,
    S_JAL
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALUC_ADD = 3'd0;
  localparam logic [2:0] ALUC_SUB = 3'd1;
  localparam logic [2:0] ALUC_AND = 3'd2;
  localparam logic [2:0] ALUC_OR  = 3'd3;
  localparam logic [2:0] ALUC_SLT = 3'd5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_ITYPE: imm_src = IMM_I;
      OP_STORE:          imm_src = IMM_S;
      OP_BRANCH:         imm_src = IMM_B;
      OP_JAL:            imm_src = IMM_J;
      default:           imm_src = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALU decoder: maps ALUOp plus funct fields to an ALUControl code,
// zero-extended to the configured width.
module alu_decoder
  import multicycle_control_unit_pkg::*;
#(
  parameter int ALUC_W = 3
) (
  input  aluop_t            aluop,
  input  logic [2:0]        fun3,
  input  logic              op5,
  input  logic              fun75,
  output logic [ALUC_W-1:0] alucontrol
);

  logic [2:0] code;

  always_comb begin
    code = ALUC_ADD;
    case (aluop)
      ALUOP_ADD: code = ALUC_ADD;
      ALUOP_SUB: code = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (fun3)
          // only R-type with funct7[5] set is a subtract; addi ignores it
          F3_ADD:  code = (op5 & fun75) ? ALUC_SUB : ALUC_ADD;
          F3_SLT:  code = ALUC_SLT;
          F3_OR:   code = ALUC_OR;
          F3_AND:  code = ALUC_AND;
          default: code = ALUC_ADD;
        endcase
      end
      default: code = ALUC_ADD;
    endcase
    alucontrol = ALUC_W'(code);
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V control unit: inline sequencing FSM with memory
// handshake, plus the ALU decoder sub-module.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4, wait for mem_ready
// DECODE   | compute branch/jal target, dispatch on opcode
// MEMADR   | compute load/store address rs1+imm
// MEMREAD  | read data memory, wait for mem_ready
// MEMWB    | write loaded data to rd
// MEMWRITE | write data memory, hold MemWrite until mem_ready
// EXECUTER | register-register ALU op
// EXECUTEI | register-immediate ALU op
// ALUWB    | write ALU result to rd
// BRANCH   | compare rs1/rs2, conditionally load target into PC
// JAL      | load jump target into PC, compute link address
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int ALUC_W        = 3,
  parameter bit EN_BNE        = 1'b1,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        Op,
  input  logic [2:0]        fun3,
  input  logic              fun75,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              PCWrite,
  output logic              AdrSrc,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic              RegWrite,
  output logic [1:0]        ResultSrc,
  output logic [1:0]        ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ImmSrc,
  output logic [ALUC_W-1:0] ALUControl,
  output logic              illegal_instr,
  output logic              instr_done
);

  state_t state, state_nxt;
  aluop_t aluop;
  logic   mem_rdy;
  logic   op_legal;
  logic   is_beq, is_bne;

  assign mem_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign is_beq  = (fun3 == F3_BEQ);
  assign is_bne  = EN_BNE && (fun3 == F3_BNE);

  always_comb begin
    case (Op)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (mem_rdy) state_nxt = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_EXECUTER;
          OP_ITYPE:          state_nxt = S_EXECUTEI;
          OP_BRANCH:         state_nxt = S_BRANCH;
          OP_JAL:            state_nxt = S_JAL;
          default:           state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR:   state_nxt = Op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_rdy) state_nxt = S_MEMWB;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: if (mem_rdy) state_nxt = S_FETCH;
      S_EXECUTER: state_nxt = S_ALUWB;
      S_EXECUTEI: state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
      S_JAL:      state_nxt = S_ALUWB;
      default:    state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite       = 1'b0;
    AdrSrc        = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RS2;
    aluop         = ALUOP_ADD;
    illegal_instr = 1'b0;
    instr_done    = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_rdy;
        PCWrite   = mem_rdy;
      end
      S_DECODE: begin
        ALUSrcA       = SRCA_OLDPC;
        ALUSrcB       = SRCB_IMM;
        illegal_instr = !op_legal;
        instr_done    = !op_legal;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_rdy;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        aluop   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA       = SRCA_RS1;
        aluop         = ALUOP_SUB;
        instr_done    = 1'b1;
        PCWrite       = (is_beq & zero) | (is_bne & !zero);
        illegal_instr = !(is_beq | is_bne);
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign ImmSrc = imm_src(Op);

  alu_decoder #(.ALUC_W(ALUC_W)) u_alu_decoder (
    .aluop      (aluop),
    .fun3       (fun3),
    .op5        (Op[5]),
    .fun75      (fun75),
    .alucontrol (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: three configurations in lockstep,
// per-cycle expected outputs queued at drive time and compared at negedge.
module tb_multicycle_control_unit;

  typedef enum int {
    T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
    T_EXECUTER, T_EXECUTEI, T_ALUWB, T_BRANCH, T_JAL
  } st_e;

  typedef struct {
    string       tag;
    logic [18:0] e_dflt;
    logic [18:0] e_nobne;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready, fun75;
  logic [6:0] Op;
  logic [2:0] fun3;

  logic       a_pcw, a_adr, a_mw, a_irw, a_rw, a_ill, a_done;
  logic [1:0] a_res, a_sa, a_sb, a_imm;
  logic [2:0] a_aluc;
  logic       b_pcw, b_adr, b_mw, b_irw, b_rw, b_ill, b_done;
  logic [1:0] b_res, b_sa, b_sb, b_imm;
  logic [2:0] b_aluc;
  logic       c_pcw, c_adr, c_mw, c_irw, c_rw, c_ill, c_done;
  logic [1:0] c_res, c_sa, c_sb, c_imm;
  logic [3:0] c_aluc;

  int    n_checks = 0;
  int    n_errors = 0;
  exp_t  sb[$];
  exp_t  cur;
  string cur_name;
  logic [6:0] n_op;
  logic [2:0] n_f3;
  logic       n_f75;

  always #5 clk = ~clk;

  multicycle_control_unit dut_dflt (
    .clk(clk), .reset(reset), .Op(Op), .fun3(fun3), .fun75(fun75), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(a_pcw), .AdrSrc(a_adr), .MemWrite(a_mw),
    .IRWrite(a_irw), .RegWrite(a_rw), .ResultSrc(a_res), .ALUSrcA(a_sa),
    .ALUSrcB(a_sb), .ImmSrc(a_imm), .ALUControl(a_aluc),
    .illegal_instr(a_ill), .instr_done(a_done));

  multicycle_control_unit #(.EN_BNE(1'b0)) dut_nobne (
    .clk(clk), .reset(reset), .Op(Op), .fun3(fun3), .fun75(fun75), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(b_pcw), .AdrSrc(b_adr), .MemWrite(b_mw),
    .IRWrite(b_irw), .RegWrite(b_rw), .ResultSrc(b_res), .ALUSrcA(b_sa),
    .ALUSrcB(b_sb), .ImmSrc(b_imm), .ALUControl(b_aluc),
    .illegal_instr(b_ill), .instr_done(b_done));

  multicycle_control_unit #(.ALUC_W(4)) dut_w4 (
    .clk(clk), .reset(reset), .Op(Op), .fun3(fun3), .fun75(fun75), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(c_pcw), .AdrSrc(c_adr), .MemWrite(c_mw),
    .IRWrite(c_irw), .RegWrite(c_rw), .ResultSrc(c_res), .ALUSrcA(c_sa),
    .ALUSrcB(c_sb), .ImmSrc(c_imm), .ALUControl(c_aluc),
    .illegal_instr(c_ill), .instr_done(c_done));

  // Packed as {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,SrcA,SrcB,ImmSrc,ALUControl[3:0],illegal,done}
  function automatic logic [18:0] exp_out(input st_e st, input logic [6:0] op,
      input logic [2:0] f3, input logic f75, input logic z, input logic mr,
      input bit en_bne);
    logic pcw, adr, mw, irw, rw, ill, done;
    logic [1:0] res, sa, sbs, imm;
    logic [3:0] aluc;
    logic [3:0] fcode;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0; done = 0;
    res = 2'b00; sa = 2'b00; sbs = 2'b00; aluc = 4'd0;
    case (op)
      7'b0000011, 7'b0010011: imm = 2'b00;
      7'b0100011:             imm = 2'b01;
      7'b1100011:             imm = 2'b10;
      7'b1101111:             imm = 2'b11;
      default:                imm = 2'b00;
    endcase
    case (f3)
      3'b000:  fcode = (op[5] && f75) ? 4'd1 : 4'd0;
      3'b010:  fcode = 4'd5;
      3'b110:  fcode = 4'd3;
      3'b111:  fcode = 4'd2;
      default: fcode = 4'd0;
    endcase
    case (st)
      T_FETCH:    begin sbs = 2'b10; res = 2'b10; pcw = mr; irw = mr; end
      T_DECODE: begin
        sa = 2'b01; sbs = 2'b01;
        if (!(op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                         7'b1100011, 7'b1101111})) begin ill = 1; done = 1; end
      end
      T_MEMADR:   begin sa = 2'b10; sbs = 2'b01; end
      T_MEMREAD:  adr = 1;
      T_MEMWB:    begin res = 2'b01; rw = 1; done = 1; end
      T_MEMWRITE: begin adr = 1; mw = 1; done = mr; end
      T_EXECUTER: begin sa = 2'b10; aluc = fcode; end
      T_EXECUTEI: begin sa = 2'b10; sbs = 2'b01; aluc = fcode; end
      T_ALUWB:    begin rw = 1; done = 1; end
      T_BRANCH: begin
        sa = 2'b10; aluc = 4'd1; done = 1;
        if (f3 == 3'b000) pcw = z;
        else if (f3 == 3'b001 && en_bne) pcw = !z;
        else ill = 1;
      end
      T_JAL:      begin sa = 2'b01; sbs = 2'b10; pcw = 1; end
      default: ;
    endcase
    return {pcw, adr, mw, irw, rw, res, sa, sbs, imm, aluc, ill, done};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, expv);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      check({cur.tag, "/dflt"}, 32'({a_pcw, a_adr, a_mw, a_irw, a_rw, a_res, a_sa, a_sb,
            a_imm, 1'b0, a_aluc, a_ill, a_done}), 32'(cur.e_dflt));
      check({cur.tag, "/nobne"}, 32'({b_pcw, b_adr, b_mw, b_irw, b_rw, b_res, b_sa, b_sb,
            b_imm, 1'b0, b_aluc, b_ill, b_done}), 32'(cur.e_nobne));
      check({cur.tag, "/w4"}, 32'({c_pcw, c_adr, c_mw, c_irw, c_rw, c_res, c_sa, c_sb,
            c_imm, c_aluc, c_ill, c_done}), 32'(cur.e_dflt));
    end
  end

  task automatic instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                       input logic f75);
    cur_name = name; n_op = op; n_f3 = f3; n_f75 = f75;
  endtask

  // One cycle: apply inputs just after the edge, queue the expected outputs.
  task automatic step(input st_e st, input logic mr, input logic z, input logic rst);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; mem_ready = mr; zero = z;
    Op = n_op; fun3 = n_f3; fun75 = n_f75;
    e.tag     = {cur_name, ".", st.name()};
    e.e_dflt  = exp_out(st, n_op, n_f3, n_f75, z, mr, 1'b1);
    e.e_nobne = exp_out(st, n_op, n_f3, n_f75, z, mr, 1'b0);
    sb.push_back(e);
  endtask

  task automatic run_alu(input string name, input logic [6:0] op, input logic [2:0] f3,
                         input logic f75);
    instr(name, op, f3, f75);
    step(T_FETCH, 1, 0, 0);
    step(T_DECODE, 1, 0, 0);
    step(op[5] ? T_EXECUTER : T_EXECUTEI, 1, 0, 0);
    step(T_ALUWB, 1, 0, 0);
  endtask

  task automatic run_branch(input string name, input logic [2:0] f3, input logic z);
    instr(name, 7'b1100011, f3, 0);
    step(T_FETCH, 1, z, 0);
    step(T_DECODE, 1, z, 0);
    step(T_BRANCH, 1, z, 0);
  endtask

  initial begin
    reset = 1; zero = 0; mem_ready = 0; Op = 0; fun3 = 0; fun75 = 0;
    instr("rst", 7'b0000000, 3'b000, 0);
    repeat (2) @(posedge clk);
    step(T_FETCH, 0, 0, 1);
    step(T_FETCH, 1, 0, 1);
    step(T_FETCH, 0, 0, 0);

    run_alu("add", 7'b0110011, 3'b000, 0);
    run_alu("sub", 7'b0110011, 3'b000, 1);
    run_alu("slt", 7'b0110011, 3'b010, 0);
    run_alu("and", 7'b0110011, 3'b111, 0);
    run_alu("xor", 7'b0110011, 3'b100, 1);
    run_alu("ori", 7'b0010011, 3'b110, 0);
    run_alu("addi_f75", 7'b0010011, 3'b000, 1);

    instr("lw", 7'b0000011, 3'b010, 0);
    step(T_FETCH, 0, 0, 0);
    step(T_FETCH, 1, 0, 0);
    step(T_DECODE, 1, 0, 0);
    step(T_MEMADR, 1, 0, 0);
    repeat (3) step(T_MEMREAD, 0, 0, 0);
    step(T_MEMREAD, 1, 0, 0);
    step(T_MEMWB, 1, 0, 0);

    instr("sw", 7'b0100011, 3'b010, 0);
    step(T_FETCH, 1, 0, 0);
    step(T_DECODE, 1, 0, 0);
    step(T_MEMADR, 1, 0, 0);
    repeat (2) step(T_MEMWRITE, 0, 0, 0);
    step(T_MEMWRITE, 1, 0, 0);

    run_branch("beq_z1", 3'b000, 1);
    run_branch("beq_z0", 3'b000, 0);
    run_branch("bne_z1", 3'b001, 1);
    run_branch("bne_z0", 3'b001, 0);
    run_branch("blt", 3'b100, 1);

    instr("jal", 7'b1101111, 3'b000, 0);
    step(T_FETCH, 1, 0, 0);
    step(T_DECODE, 1, 0, 0);
    step(T_JAL, 1, 0, 0);
    step(T_ALUWB, 1, 0, 0);

    instr("illegal", 7'b1111111, 3'b000, 0);
    step(T_FETCH, 1, 0, 0);
    step(T_DECODE, 1, 0, 0);
    step(T_FETCH, 0, 0, 0);

    instr("sw_rst", 7'b0100011, 3'b000, 0);
    step(T_FETCH, 1, 0, 0);
    step(T_DECODE, 1, 0, 0);
    step(T_MEMADR, 1, 0, 0);
    step(T_MEMWRITE, 0, 0, 0);
    step(T_MEMWRITE, 0, 0, 1);
    step(T_FETCH, 0, 0, 0);

    instr("lw_rst", 7'b0000011, 3'b000, 0);
    step(T_FETCH, 1, 0, 0);
    step(T_DECODE, 1, 0, 0);
    step(T_MEMADR, 1, 0, 0);
    step(T_MEMREAD, 0, 0, 1);
    step(T_FETCH, 1, 0, 0);
    step(T_DECODE, 1, 0, 0);

    repeat (2) @(posedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
